// File: rtl/str_pkg.sv
// Shared helpers for the vld/rdy stream width converters (serializer/deserializer).
package str_pkg;

  // Beat counter width; a 1-lane word still needs a 1-bit counter.
  function automatic int str_cnt_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Bit offset of a lane inside a packed wide word.
  function automatic int str_lane_off(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/str_serializer.sv
// Wide-to-narrow stream converter: one RATIO-lane word in, RATIO beats out,
// final beat flagged with oup_str_last. Outputs registered, input ready combinational.
module str_serializer
  import str_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RATIO     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [WIDTH*RATIO-1:0] inp_str_data,
  input  logic                   inp_str_vld,
  output logic                   inp_str_rdy,
  output logic [WIDTH-1:0]       oup_str_data,
  output logic                   oup_str_vld,
  output logic                   oup_str_last,
  input  logic                   oup_str_rdy
);

  localparam int TW        = WIDTH * RATIO;
  localparam int CW        = str_cnt_w(RATIO);
  // The lane presented next always sits at the same offset; the shift direction brings it there.
  localparam int FIRST_OFF = str_lane_off(LSB_FIRST ? 0 : RATIO - 1, WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);
  localparam logic [CW-1:0] PENULT   = CW'((RATIO > 1) ? RATIO - 2 : 0);

  logic [TW-1:0] sreg;
  logic [TW-1:0] sreg_adv;
  logic [CW-1:0] cnt;
  logic          oup_vld_i;
  logic          is_last;
  logic          in_fire;
  logic          out_fire;

  assign is_last     = (cnt == LAST_CNT);
  assign inp_str_rdy = !oup_vld_i | (oup_str_rdy & is_last);
  assign in_fire     = inp_str_vld & inp_str_rdy;
  assign out_fire    = oup_vld_i & oup_str_rdy;
  assign oup_str_vld = oup_vld_i;
  assign sreg_adv    = LSB_FIRST ? (sreg >> WIDTH) : (sreg << WIDTH);

  // Loading a new word wins over retiring the final beat, so back-to-back words have no bubble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      oup_vld_i    <= 1'b0;
      oup_str_last <= 1'b0;
      cnt          <= '0;
    end else if (in_fire) begin
      sreg         <= inp_str_data;
      cnt          <= '0;
      oup_vld_i    <= 1'b1;
      oup_str_data <= inp_str_data[FIRST_OFF +: WIDTH];
      oup_str_last <= (RATIO == 1);
    end else if (out_fire && !is_last) begin
      sreg         <= sreg_adv;
      cnt          <= cnt + 1'b1;
      oup_str_data <= sreg_adv[FIRST_OFF +: WIDTH];
      oup_str_last <= (cnt == PENULT);
    end else if (out_fire) begin
      oup_vld_i    <= 1'b0;
      oup_str_last <= 1'b0;
      cnt          <= '0;
    end
  end

endmodule
